tor_ctrl_sync_slave: RTL

- ToR-side end of the controller control channel. Implements the slave half of the three-phase exchange S_TS → RETURN_TS → M_STD.
- Sends the local timestamp, receives the master's return, and corrects the local time by half the measured round trip.
- Each M_STD command is turned into slot-start and slot-ID outputs for the ToR VLB and scheduler logic.
- Sits between the ctrl-channel MAC stream (GT channel 2) and the ToR slot scheduler.

---
 rtl/tor_ctrl_pkg.sv | 33 +++
 rtl/tor_ctrl_rx_parser.sv | 65 ++++++
 rtl/tor_ctrl_sync_slave.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tor_ctrl_pkg.sv
// Shared definitions for the controller control channel (ToR slave and controller port logic).
package tor_ctrl_pkg;

    localparam logic [7:0] CTRL_S_TS   = 8'h01;
    localparam logic [7:0] CTRL_RET_TS = 8'h02;
    localparam logic [7:0] CTRL_M_STD  = 8'h03;

    // Beat0 field offsets
    localparam int TYPE_MSB = 63;
    localparam int TYPE_LSB = 56;
    localparam int SLOT_MSB = 55;
    localparam int SLOT_LSB = 48;

    typedef enum logic [2:0] {
        IDLE,
        SEND_S_TS,
        WAIT_RET,
        WAIT_STD,
        RUN
    } sync_state_t;

    typedef enum logic [1:0] {
        RX_BEAT0,
        RX_RET1,
        RX_RET2,
        RX_DROP
    } rx_beat_t;

    function automatic logic [63:0] make_beat0(input logic [7:0] ftype, input logic [7:0] slot);
        return {ftype, slot, 48'h0};
    endfunction

endpackage

// File: rtl/tor_ctrl_rx_parser.sv
// Control-channel rx frame parser: checks type and length, emits one-cycle pulses for
// complete RETURN_TS and M_STD frames with their captured fields.
module tor_ctrl_rx_parser
    import tor_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [63:0] rx_data,
    input  logic        rx_last,
    input  logic [63:0] local_time,
    output logic        ret_ts_vld,
    output logic [63:0] t1_echo,
    output logic [63:0] tm,
    output logic [63:0] t2,
    output logic        m_std_vld,
    output logic [7:0]  slot_id,
    output logic [1:0]  rx_state_dbg
);

    rx_beat_t   rx_state, rx_next;
    logic [7:0] beat_type;

    assign beat_type    = rx_data[TYPE_MSB:TYPE_LSB];
    assign rx_state_dbg = rx_state;

    // Anything that is not a correctly sized RETURN_TS or M_STD is discarded up to rx_last.
    always_comb begin
        rx_next = rx_state;
        if (rx_valid) begin
            case (rx_state)
                RX_BEAT0: if (!rx_last) rx_next = (beat_type == CTRL_RET_TS) ? RX_RET1 : RX_DROP;
                RX_RET1:  rx_next = rx_last ? RX_BEAT0 : RX_RET2;
                RX_RET2:  rx_next = rx_last ? RX_BEAT0 : RX_DROP;
                RX_DROP:  if (rx_last) rx_next = RX_BEAT0;
                default:  rx_next = RX_BEAT0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_BEAT0;
            ret_ts_vld <= 1'b0;
            m_std_vld  <= 1'b0;
            t1_echo    <= '0;
            tm         <= '0;
            t2         <= '0;
            slot_id    <= '0;
        end else begin
            rx_state   <= rx_next;
            ret_ts_vld <= rx_valid && rx_last && (rx_state == RX_RET2);
            m_std_vld  <= rx_valid && rx_last && (rx_state == RX_BEAT0) && (beat_type == CTRL_M_STD);
            if (rx_valid) begin
                if (rx_state == RX_BEAT0) begin
                    t2      <= local_time;
                    slot_id <= rx_data[SLOT_MSB:SLOT_LSB];
                end
                if (rx_state == RX_RET1) t1_echo <= rx_data;
                if (rx_state == RX_RET2) tm      <= rx_data;
            end
        end
    end

endmodule

// File: rtl/tor_ctrl_sync_slave.sv
// ToR slave of the S_TS / RETURN_TS / M_STD exchange: time sync and slot start generation.
// Optional statistics counters are built when TOR_SYNC_STAT_EN is defined.
module tor_ctrl_sync_slave
    import tor_ctrl_pkg::*;
#(
    parameter logic [31:0] P_TS_TIMEOUT = 32'd4096,
    parameter logic [7:0]  P_MAX_RETRY  = 8'd8,
    parameter logic [15:0] P_PIPE_COMP  = 16'd4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_link_up,
    input  logic        i_rx_valid,
    input  logic [63:0] i_rx_data,
    input  logic        i_rx_last,
    output logic        o_tx_valid,
    output logic [63:0] o_tx_data,
    output logic        o_tx_last,
    input  logic        i_tx_ready,
    output logic [63:0] o_local_time,
    output logic        o_synced,
    output logic        o_sim_start,
    output logic        o_slot_start,
    output logic [7:0]  o_slot_id,
    output logic        o_sync_err,
    output logic [15:0] o_sync_cnt,
    output logic [15:0] o_timeout_cnt,
    output logic [2:0]  o_fsm_state
);

    sync_state_t state, state_next;
    logic [63:0] local_time, t1_q, corr_time;
    logic [31:0] timer;
    logic [7:0]  retry, retry_inc, slot_id_q;
    logic        tx_beat, tx_fire, timeout, ret_ok, std_ok, to_ev;
    logic        synced, sim_start, sync_err;

    logic        ret_ts_vld, m_std_vld;
    logic [63:0] ret_t1, ret_tm, ret_t2;
    logic [7:0]  p_slot_id;
    logic [1:0]  rx_state_dbg;

    tor_ctrl_rx_parser u_rx_parser (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .rx_valid     (i_rx_valid),
        .rx_data      (i_rx_data),
        .rx_last      (i_rx_last),
        .local_time   (local_time),
        .ret_ts_vld   (ret_ts_vld),
        .t1_echo      (ret_t1),
        .tm           (ret_tm),
        .t2           (ret_t2),
        .m_std_vld    (m_std_vld),
        .slot_id      (p_slot_id),
        .rx_state_dbg (rx_state_dbg)
    );

    assign tx_fire   = o_tx_valid && i_tx_ready;
    assign timeout   = ((state == WAIT_RET) || (state == WAIT_STD)) && (timer == P_TS_TIMEOUT - 32'd1);
    assign ret_ok    = (state == WAIT_RET) && ret_ts_vld && (ret_t1 == t1_q);
    assign std_ok    = ((state == WAIT_STD) || (state == RUN)) && m_std_vld;
    assign to_ev     = timeout && !ret_ok && !std_ok && i_link_up;
    assign retry_inc = (retry == 8'hFF) ? retry : retry + 8'd1;

    // The loaded value is first visible one cycle after the apply cycle, so elapsed includes it.
    assign corr_time = ret_tm + ((ret_t2 - t1_q) >> 1) + {48'd0, P_PIPE_COMP}
                     + (local_time - ret_t2) + 64'd1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (i_link_up) state_next = SEND_S_TS;
            SEND_S_TS: if (tx_fire && tx_beat) state_next = WAIT_RET;
            WAIT_RET:  if (ret_ok) state_next = WAIT_STD;
                       else if (timeout) state_next = SEND_S_TS;
            WAIT_STD:  if (std_ok) state_next = RUN;
                       else if (timeout) state_next = SEND_S_TS;
            RUN:       state_next = RUN;
            default:   state_next = IDLE;
        endcase
        if (!i_link_up) state_next = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            local_time <= '0;
            t1_q       <= '0;
            timer      <= '0;
            retry      <= '0;
            tx_beat    <= 1'b0;
            synced     <= 1'b0;
            sim_start  <= 1'b0;
            sync_err   <= 1'b0;
            slot_id_q  <= '0;
        end else begin
            state      <= state_next;
            local_time <= ret_ok ? corr_time : local_time + 64'd1;

            if (((state == WAIT_RET) || (state == WAIT_STD)) && (state_next == state))
                timer <= timer + 32'd1;
            else
                timer <= '0;

            if (tx_fire) begin
                if (!tx_beat) t1_q <= local_time;
                tx_beat <= ~tx_beat;
            end else if (state != SEND_S_TS) begin
                tx_beat <= 1'b0;
            end

            if (!i_link_up) begin
                synced    <= 1'b0;
                sim_start <= 1'b0;
                retry     <= '0;
            end else begin
                if (ret_ok) begin
                    synced <= 1'b1;
                    retry  <= '0;
                end else if (to_ev) begin
                    retry <= retry_inc;
                    if (retry_inc >= P_MAX_RETRY) sync_err <= 1'b1;
                end
                if (std_ok) begin
                    sim_start <= 1'b1;
                    slot_id_q <= p_slot_id;
                end
            end
        end
    end

    assign o_tx_valid   = (state == SEND_S_TS);
    assign o_tx_last    = o_tx_valid && tx_beat;
    assign o_tx_data    = !o_tx_valid ? 64'd0 : (tx_beat ? t1_q : make_beat0(CTRL_S_TS, 8'h00));
    assign o_local_time = local_time;
    assign o_synced     = synced;
    assign o_sim_start  = sim_start;
    assign o_slot_start = std_ok;
    assign o_slot_id    = std_ok ? p_slot_id : slot_id_q;
    assign o_sync_err   = sync_err;
    assign o_fsm_state  = state;

`ifdef TOR_SYNC_STAT_EN
    logic [15:0] sync_cnt, to_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if (ret_ok && (sync_cnt != 16'hFFFF)) sync_cnt <= sync_cnt + 16'd1;
            if (to_ev && (to_cnt != 16'hFFFF))    to_cnt   <= to_cnt + 16'd1;
        end
    end

    assign o_sync_cnt    = sync_cnt;
    assign o_timeout_cnt = to_cnt;
`else
    assign o_sync_cnt    = '0;
    assign o_timeout_cnt = '0;
`endif

endmodule
